// File: rtl/motor_cmd_arbiter_if.sv
// motor_cmd_arbiter_if: command handshakes from the IR/UART decoders, proximity input, motor/PWM status outputs
//   master: decoder/sensor side (drives valid/cmd/prox_stat, observes ready and motor status)
//   slave : arbiter side (drives ready, motor_stat, duty, cmd_src, busy, cmd_err)
interface motor_cmd_arbiter_if;
  logic       ir_valid;
  logic [2:0] ir_cmd;
  logic       ir_ready;
  logic       uart_valid;
  logic [2:0] uart_cmd;
  logic       uart_ready;
  logic [3:0] prox_stat;
  logic [2:0] motor_stat;
  logic [6:0] duty;
  logic       cmd_src;
  logic       busy;
  logic       cmd_err;
  modport master (
    output ir_valid, ir_cmd, uart_valid, uart_cmd, prox_stat,
    input  ir_ready, uart_ready, motor_stat, duty, cmd_src, busy, cmd_err
  );
  modport slave (
    input  ir_valid, ir_cmd, uart_valid, uart_cmd, prox_stat,
    output ir_ready, uart_ready, motor_stat, duty, cmd_src, busy, cmd_err
  );
endinterface

// File: rtl/motor_cmd_arbiter.sv
// motor_cmd_arbiter: arbitrates IR/UART motor commands with brake dead-time and a stale-command watchdog
//   CLK, RESET : clock and synchronous active-high reset
//   bus        : motor_cmd_arbiter_if.slave (IR/UART valid-ready handshakes, prox_stat in,
//                motor_stat/duty/cmd_src/busy/cmd_err registered out)
//   OBSTACLE_STOP_EN : when defined, forward motion is braked while prox_stat <= STOP_THRESH
module motor_cmd_arbiter #(
  parameter int         TIMEOUT_CYCLES = 5_000_000,
  parameter int         DEAD_CYCLES    = 500_000,
  parameter logic [3:0] NEAR_THRESH    = 4'd8,
  parameter logic [6:0] FAR_DUTY       = 7'd60,
  parameter logic [6:0] NEAR_DUTY      = 7'd40,
  parameter logic [3:0] STOP_THRESH    = 4'd2
) (
  input logic CLK,
  input logic RESET,
  motor_cmd_arbiter_if.slave bus
);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = $clog2(DEAD_CYCLES + 1);
`ifdef OBSTACLE_STOP_EN
  localparam logic OBST_EN = 1'b1;
`else
  localparam logic OBST_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, RUN, DEAD, STOP} state_t;
  state_t state, state_n;
  logic [2:0] cur, cur_n, pend, pend_n, cmd, mot_n;
  logic [WW-1:0] wd, wd_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [6:0] duty_n;
  logic accept_ok, xfer_ir, xfer, bad, src_n, err_n, obst, busy_n;
  function automatic logic moving(input logic [2:0] c);
    return c == 3'b001 || c == 3'b010 || c == 3'b100 || c == 3'b101;
  endfunction
  assign accept_ok = !RESET && (state == IDLE || state == RUN);
  assign bus.ir_ready = accept_ok;
  assign bus.uart_ready = accept_ok && !bus.ir_valid;
  assign xfer_ir = bus.ir_valid && accept_ok;
  assign xfer = xfer_ir || (bus.uart_valid && bus.uart_ready);
  assign cmd = xfer_ir ? bus.ir_cmd : bus.uart_cmd;
  assign bad = cmd[2] && cmd[1];
  always_comb begin
    state_n = state;
    cur_n = cur;
    pend_n = pend;
    cnt_n = cnt;
    wd_n = wd;
    src_n = bus.cmd_src;
    err_n = 1'b0;
    case (state)
      IDLE, RUN: begin
        if (state == RUN) begin
          wd_n = wd + 1'b1;
          if (wd == WW'(TIMEOUT_CYCLES - 1)) begin
            state_n = STOP;
            wd_n = '0;
          end
        end
        // an invalid code only pulses the error; a valid one overrides a coincident timeout
        if (xfer && bad) err_n = 1'b1;
        else if (xfer) begin
          src_n = !xfer_ir;
          wd_n = '0;
          if (cmd == 3'b000) begin
            state_n = IDLE;
            cur_n = 3'b000;
          end else if (moving(cmd) && moving(cur) && cmd != cur) begin
            state_n = DEAD;
            pend_n = cmd;
          end else begin
            state_n = RUN;
            cur_n = cmd;
          end
        end
      end
      default: begin
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(DEAD_CYCLES - 1)) begin
          cnt_n = '0;
          state_n = state == DEAD ? RUN : IDLE;
          cur_n = state == DEAD ? pend : 3'b000;
        end
      end
    endcase
  end
  assign obst = OBST_EN && cur_n == 3'b001 && bus.prox_stat <= STOP_THRESH;
  assign busy_n = state_n == DEAD || state_n == STOP;
  assign mot_n = state_n == IDLE ? 3'b000 : (busy_n || obst) ? 3'b011 : cur_n;
  assign duty_n = (mot_n == 3'b000 || mot_n == 3'b011) ? 7'd0 :
                  bus.prox_stat > NEAR_THRESH ? FAR_DUTY : NEAR_DUTY;
  always_ff @(posedge CLK)
    if (RESET) begin
      state <= IDLE;
      cur <= 3'b000;
      pend <= 3'b000;
      wd <= '0;
      cnt <= '0;
      bus.motor_stat <= 3'b000;
      bus.duty <= 7'd0;
      bus.cmd_src <= 1'b0;
      bus.busy <= 1'b0;
      bus.cmd_err <= 1'b0;
    end else begin
      state <= state_n;
      cur <= cur_n;
      pend <= pend_n;
      wd <= wd_n;
      cnt <= cnt_n;
      bus.motor_stat <= mot_n;
      bus.duty <= duty_n;
      bus.cmd_src <= src_n;
      bus.busy <= busy_n;
      bus.cmd_err <= err_n;
    end
endmodule

// File: tb/tb_motor_cmd_arbiter.sv
// tb_motor_cmd_arbiter: vector table, corner sequences and random traffic against a reference model
module tb_motor_cmd_arbiter;
  localparam int T = 10;
  localparam int D = 4;
`ifdef OBSTACLE_STOP_EN
  localparam bit OBST = 1'b1;
`else
  localparam bit OBST = 1'b0;
`endif
  typedef struct packed {
    logic r, iv;
    logic [2:0] ic;
    logic uv;
    logic [2:0] uc;
    logic [3:0] p;
  } in_t;
  typedef struct {
    in_t i;
    logic [1:0] rdy;
    logic [2:0] mot;
    logic [6:0] duty;
    logic [2:0] bse;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  logic [1:0] obs_rdy;
  logic [12:0] obs_out;
  int m_brake, m_stale;
  logic [2:0] m_cur, m_after;
  logic m_src, m_err;
  logic [3:0] m_prox;
  vec_t tv[18];
  always #5 clk = ~clk;
  motor_cmd_arbiter_if bus();
  motor_cmd_arbiter #(.TIMEOUT_CYCLES(T), .DEAD_CYCLES(D)) dut (.CLK(clk), .RESET(rst), .bus(bus));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic is_moving(input logic [2:0] c);
    return c inside {3'd1, 3'd2, 3'd4, 3'd5};
  endfunction
  // reference: the motor is "commanded" whenever m_cur != 0; a pending brake of m_brake cycles
  // precedes adopting m_after; m_stale counts commanded cycles since the last good command
  task automatic model_step(input in_t x);
    logic [2:0] c;
    m_err = 1'b0;
    m_prox = x.p;
    if (x.r) begin
      m_cur = 3'd0;
      m_brake = 0;
      m_after = 3'd0;
      m_stale = 0;
      m_src = 1'b0;
      return;
    end
    if (m_brake > 0) begin
      m_brake--;
      if (m_brake == 0) m_cur = m_after;
      return;
    end
    c = x.iv ? x.ic : x.uc;
    if ((x.iv || x.uv) && c <= 3'd5) begin
      m_stale = 0;
      m_src = !x.iv;
      if (is_moving(c) && is_moving(m_cur) && c != m_cur) begin
        m_brake = D;
        m_after = c;
      end else m_cur = c;
    end else begin
      m_err = x.iv || x.uv;
      if (m_cur != 3'd0) begin
        m_stale++;
        if (m_stale == T) begin
          m_brake = D;
          m_after = 3'd0;
          m_stale = 0;
        end
      end
    end
  endtask
  function automatic logic [12:0] exp_out();
    logic [2:0] mot;
    logic [6:0] du;
    mot = (m_brake > 0 || (OBST && m_cur == 3'd1 && m_prox <= 4'd2)) ? 3'd3 : m_cur;
    du = (mot == 3'd0 || mot == 3'd3) ? 7'd0 : m_prox > 4'd8 ? 7'd60 : 7'd40;
    return {mot, du, m_brake > 0, m_src, m_err};
  endfunction
  task automatic tick(input in_t x);
    logic ok;
    rst = x.r;
    bus.ir_valid = x.iv;
    bus.ir_cmd = x.ic;
    bus.uart_valid = x.uv;
    bus.uart_cmd = x.uc;
    bus.prox_stat = x.p;
    #1;
    ok = !x.r && m_brake == 0;
    obs_rdy = {bus.ir_ready, bus.uart_ready};
    chk("model_ready", 32'(obs_rdy), 32'({ok, ok && !x.iv}));
    model_step(x);
    @(posedge clk);
    #1;
    obs_out = {bus.motor_stat, bus.duty, bus.busy, bus.cmd_src, bus.cmd_err};
    chk("model_out", 32'(obs_out), 32'(exp_out()));
  endtask
  function automatic in_t mk(input logic r, iv, input logic [2:0] ic, input logic uv,
                             input logic [2:0] uc, input logic [3:0] p);
    return {r, iv, ic, uv, uc, p};
  endfunction
  function automatic in_t rs();
    return mk(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 4'd15);
  endfunction
  function automatic in_t ir(input logic [2:0] c);
    return mk(1'b0, 1'b1, c, 1'b0, 3'd0, 4'd15);
  endfunction
  function automatic in_t ua(input logic [2:0] c);
    return mk(1'b0, 1'b0, 3'd0, 1'b1, c, 4'd15);
  endfunction
  function automatic in_t idl(input logic [3:0] p);
    return mk(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, p);
  endfunction
  function automatic vec_t v(input in_t i, input logic [1:0] rdy, input logic [2:0] mot,
                             input logic [6:0] du, input logic [2:0] bse);
    vec_t r;
    r.i = i;
    r.rdy = rdy;
    r.mot = mot;
    r.duty = du;
    r.bse = bse;
    return r;
  endfunction
  initial begin
    m_brake = 0;
    m_stale = 0;
    m_cur = 3'd0;
    m_after = 3'd0;
    m_src = 1'b0;
    m_err = 1'b0;
    m_prox = 4'd15;
    bus.ir_valid = 1'b0;
    bus.ir_cmd = 3'd0;
    bus.uart_valid = 1'b0;
    bus.uart_cmd = 3'd0;
    bus.prox_stat = 4'd15;
    // rdy = {ir_ready, uart_ready}; bse = {busy, cmd_src, cmd_err}
    tv[0]  = v(rs(),        2'b00, 3'd0, 7'd0,  3'b000);
    tv[1]  = v(ir(3'd1),    2'b10, 3'd1, 7'd60, 3'b000);
    tv[2]  = v(idl(4'd5),   2'b11, 3'd1, 7'd40, 3'b000);
    tv[3]  = v(ua(3'd7),    2'b11, 3'd1, 7'd60, 3'b001);
    tv[4]  = v(ua(3'd5),    2'b11, 3'd3, 7'd0,  3'b110);
    tv[5]  = v(ir(3'd2),    2'b00, 3'd3, 7'd0,  3'b110);
    tv[6]  = v(idl(4'd15),  2'b00, 3'd3, 7'd0,  3'b110);
    tv[7]  = v(idl(4'd15),  2'b00, 3'd3, 7'd0,  3'b110);
    tv[8]  = v(idl(4'd15),  2'b00, 3'd5, 7'd60, 3'b010);
    tv[9]  = v(ir(3'd0),    2'b10, 3'd0, 7'd0,  3'b000);
    tv[10] = v(mk(1'b0, 1'b1, 3'd4, 1'b1, 3'd2, 4'd15), 2'b10, 3'd4, 7'd60, 3'b000);
    tv[11] = v(ua(3'd2),    2'b11, 3'd3, 7'd0,  3'b110);
    tv[12] = v(idl(4'd15),  2'b00, 3'd3, 7'd0,  3'b110);
    tv[13] = v(idl(4'd15),  2'b00, 3'd3, 7'd0,  3'b110);
    tv[14] = v(idl(4'd15),  2'b00, 3'd3, 7'd0,  3'b110);
    tv[15] = v(idl(4'd15),  2'b00, 3'd2, 7'd60, 3'b010);
    tv[16] = v(ua(3'd3),    2'b11, 3'd3, 7'd0,  3'b010);
    tv[17] = v(ir(3'd1),    2'b10, 3'd1, 7'd60, 3'b000);
    @(posedge clk);
    #1;
    for (int k = 0; k < 18; k++) begin
      tick(tv[k].i);
      chk($sformatf("vec%0d_rdy", k), 32'(obs_rdy), 32'(tv[k].rdy));
      chk($sformatf("vec%0d_out", k), 32'(obs_out), 32'({tv[k].mot, tv[k].duty, tv[k].bse}));
    end
    // watchdog: a repeated command restarts the count, then stop brake, then idle
    tick(rs());
    tick(ir(3'd2));
    repeat (8) tick(idl(4'd15));
    chk("wd_before_repeat", 32'(bus.motor_stat), 2);
    tick(ir(3'd2));
    repeat (9) tick(idl(4'd15));
    chk("wd_restarted", 32'(bus.motor_stat), 2);
    tick(idl(4'd15));
    chk("wd_stop_mot", 32'(bus.motor_stat), 3);
    chk("wd_stop_busy", 32'(bus.busy), 1);
    repeat (3) tick(idl(4'd15));
    chk("wd_stop_hold", 32'(bus.motor_stat), 3);
    tick(idl(4'd15));
    chk("wd_idle", 32'({bus.motor_stat, bus.duty, bus.busy}), 0);
    // invalid code pulses the error without clearing the watchdog
    tick(ir(3'd1));
    repeat (5) tick(idl(4'd15));
    tick(ua(3'd7));
    chk("err_pulse", 32'({bus.cmd_err, bus.motor_stat}), 32'({1'b1, 3'd1}));
    tick(idl(4'd15));
    chk("err_one_cycle", 32'(bus.cmd_err), 0);
    tick(idl(4'd15));
    tick(idl(4'd15));
    chk("err_pre_timeout", 32'(bus.motor_stat), 1);
    tick(idl(4'd15));
    chk("err_no_wd_clear", 32'(bus.motor_stat), 3);
    // reset in the middle of a dead-time discards the pending motion
    tick(rs());
    tick(ir(3'd1));
    tick(ua(3'd5));
    chk("dead_busy", 32'(bus.busy), 1);
    tick(idl(4'd15));
    tick(rs());
    chk("rst_dead_rdy", 32'(obs_rdy), 0);
    chk("rst_dead_out", 32'(obs_out), 0);
    tick(idl(4'd15));
    chk("rst_discard", 32'({bus.motor_stat, bus.busy}), 0);
    // obstacle handling while moving forward
    tick(ir(3'd1));
    tick(idl(4'd1));
    chk("obst_near", 32'({bus.motor_stat, bus.duty}), OBST ? 32'({3'd3, 7'd0}) : 32'({3'd1, 7'd40}));
    tick(idl(4'd15));
    chk("obst_clear", 32'({bus.motor_stat, bus.duty}), 32'({3'd1, 7'd60}));
    tick(idl(4'd5));
    chk("near_duty", 32'(bus.duty), 40);
    for (int n = 0; n < 3000; n++) begin
      in_t x;
      x.r = $urandom_range(0, 149) == 0;
      x.iv = $urandom_range(0, 7) == 0;
      x.ic = 3'($urandom_range(0, 7));
      x.uv = $urandom_range(0, 5) == 0;
      x.uc = 3'($urandom_range(0, 7));
      x.p = 4'($urandom_range(0, 15));
      tick(x);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
